// File: rtl/mem_axi_arb2.sv
// Two-requester AXI4 arbiter onto one shared 64-bit memory slave port.
// AR is a registered round-robin slot; AW/W run an ownership FSM.
module mem_axi_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m0_ar_valid,
  output logic        m0_ar_ready,
  input  logic [31:0] m0_ar_addr,
  input  logic [7:0]  m0_ar_len,
  input  logic [2:0]  m0_ar_size,
  input  logic [1:0]  m0_ar_burst,
  input  logic [4:0]  m0_ar_id,
  input  logic        m1_ar_valid,
  output logic        m1_ar_ready,
  input  logic [31:0] m1_ar_addr,
  input  logic [7:0]  m1_ar_len,
  input  logic [2:0]  m1_ar_size,
  input  logic [1:0]  m1_ar_burst,
  input  logic [4:0]  m1_ar_id,
  input  logic        m0_aw_valid,
  output logic        m0_aw_ready,
  input  logic [31:0] m0_aw_addr,
  input  logic [7:0]  m0_aw_len,
  input  logic [2:0]  m0_aw_size,
  input  logic [1:0]  m0_aw_burst,
  input  logic [4:0]  m0_aw_id,
  input  logic        m1_aw_valid,
  output logic        m1_aw_ready,
  input  logic [31:0] m1_aw_addr,
  input  logic [7:0]  m1_aw_len,
  input  logic [2:0]  m1_aw_size,
  input  logic [1:0]  m1_aw_burst,
  input  logic [4:0]  m1_aw_id,
  input  logic        m0_w_valid,
  input  logic [63:0] m0_w_data,
  input  logic [7:0]  m0_w_strb,
  input  logic        m0_w_last,
  output logic        m0_w_ready,
  input  logic        m1_w_valid,
  input  logic [63:0] m1_w_data,
  input  logic [7:0]  m1_w_strb,
  input  logic        m1_w_last,
  output logic        m1_w_ready,
  output logic        m0_r_valid,
  output logic [63:0] m0_r_data,
  output logic [1:0]  m0_r_resp,
  output logic        m0_r_last,
  output logic [4:0]  m0_r_id,
  input  logic        m0_r_ready,
  output logic        m1_r_valid,
  output logic [63:0] m1_r_data,
  output logic [1:0]  m1_r_resp,
  output logic        m1_r_last,
  output logic [4:0]  m1_r_id,
  input  logic        m1_r_ready,
  output logic        m0_b_valid,
  output logic [1:0]  m0_b_resp,
  output logic [4:0]  m0_b_id,
  input  logic        m0_b_ready,
  output logic        m1_b_valid,
  output logic [1:0]  m1_b_resp,
  output logic [4:0]  m1_b_id,
  input  logic        m1_b_ready,
  output logic        s_ar_valid,
  input  logic        s_ar_ready,
  output logic [31:0] s_ar_addr,
  output logic [7:0]  s_ar_len,
  output logic [2:0]  s_ar_size,
  output logic [1:0]  s_ar_burst,
  output logic [5:0]  s_ar_id,
  output logic        s_ar_lock,
  output logic [3:0]  s_ar_cache,
  output logic [2:0]  s_ar_prot,
  output logic [3:0]  s_ar_qos,
  output logic        s_aw_valid,
  input  logic        s_aw_ready,
  output logic [31:0] s_aw_addr,
  output logic [7:0]  s_aw_len,
  output logic [2:0]  s_aw_size,
  output logic [1:0]  s_aw_burst,
  output logic [5:0]  s_aw_id,
  output logic        s_aw_lock,
  output logic [3:0]  s_aw_cache,
  output logic [2:0]  s_aw_prot,
  output logic [3:0]  s_aw_qos,
  output logic        s_w_valid,
  output logic [63:0] s_w_data,
  output logic [7:0]  s_w_strb,
  output logic        s_w_last,
  input  logic        s_w_ready,
  input  logic        s_r_valid,
  input  logic [63:0] s_r_data,
  input  logic [1:0]  s_r_resp,
  input  logic        s_r_last,
  input  logic [5:0]  s_r_id,
  output logic        s_r_ready,
  input  logic        s_b_valid,
  input  logic [1:0]  s_b_resp,
  input  logic [5:0]  s_b_id,
  output logic        s_b_ready
);

  typedef enum logic [1:0] {
    AW_IDLE,
    AW_ISSUE,
    W_BURST
  } aw_state_t;

  // last = index granted previously; the other one wins a tie
  function automatic logic pick(input logic v0,
                                input logic v1,
                                input logic last);
    if (v0 && v1)
      return (FIXED_PRIO != 0) ? 1'b0 : !last;
    return !v0;
  endfunction

  assign s_ar_lock  = 1'b0;
  assign s_ar_cache = 4'b0011;
  assign s_ar_prot  = 3'b000;
  assign s_ar_qos   = 4'b0000;
  assign s_aw_lock  = 1'b0;
  assign s_aw_cache = 4'b0011;
  assign s_aw_prot  = 3'b000;
  assign s_aw_qos   = 4'b0000;

  logic        r_ar_valid;
  logic        r_ar_last;
  logic [31:0] r_ar_addr;
  logic [7:0]  r_ar_len;
  logic [2:0]  r_ar_size;
  logic [1:0]  r_ar_burst;
  logic [5:0]  r_ar_id;
  logic        w_ar_load;
  logic        w_ar_any;
  logic        w_ar_sel;
  logic        w_ar_gnt;

  assign w_ar_load = !r_ar_valid || s_ar_ready;
  assign w_ar_any  = m0_ar_valid || m1_ar_valid;
  assign w_ar_sel  = pick(m0_ar_valid, m1_ar_valid, r_ar_last);
  assign w_ar_gnt  = reset_n && w_ar_load && w_ar_any;

  assign m0_ar_ready = w_ar_gnt && !w_ar_sel;
  assign m1_ar_ready = w_ar_gnt && w_ar_sel;

  assign s_ar_valid = r_ar_valid;
  assign s_ar_addr  = r_ar_addr;
  assign s_ar_len   = r_ar_len;
  assign s_ar_size  = r_ar_size;
  assign s_ar_burst = r_ar_burst;
  assign s_ar_id    = r_ar_id;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ar_valid <= 1'b0;
      r_ar_last  <= 1'b1;
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_ar_id    <= '0;
    end else if (w_ar_load) begin
      r_ar_valid <= w_ar_any;
      if (w_ar_gnt) begin
        r_ar_last  <= w_ar_sel;
        r_ar_addr  <= w_ar_sel ? m1_ar_addr : m0_ar_addr;
        r_ar_len   <= w_ar_sel ? m1_ar_len : m0_ar_len;
        r_ar_size  <= w_ar_sel ? m1_ar_size : m0_ar_size;
        r_ar_burst <= w_ar_sel ? m1_ar_burst : m0_ar_burst;
        r_ar_id    <= {w_ar_sel,
                       w_ar_sel ? m1_ar_id : m0_ar_id};
      end
    end
  end

  aw_state_t   r_aw_state;
  aw_state_t   w_aw_next;
  logic        r_aw_owner;
  logic        r_aw_last;
  logic        r_w_done;
  logic [31:0] r_aw_addr;
  logic [7:0]  r_aw_len;
  logic [2:0]  r_aw_size;
  logic [1:0]  r_aw_burst;
  logic [5:0]  r_aw_id;
  logic        w_aw_any;
  logic        w_aw_sel;
  logic        w_aw_gnt;
  logic        w_fwd;
  logic        w_fwd_ok;
  logic        w_own_valid;
  logic        w_own_last;
  logic        w_wlast_hs;

  assign w_aw_any = m0_aw_valid || m1_aw_valid;
  assign w_aw_sel = pick(m0_aw_valid, m1_aw_valid, r_aw_last);

  assign m0_aw_ready = w_aw_gnt && !w_aw_sel;
  assign m1_aw_ready = w_aw_gnt && w_aw_sel;

  assign s_aw_valid = (r_aw_state == AW_ISSUE);
  assign s_aw_addr  = r_aw_addr;
  assign s_aw_len   = r_aw_len;
  assign s_aw_size  = r_aw_size;
  assign s_aw_burst = r_aw_burst;
  assign s_aw_id    = r_aw_id;

  assign w_own_valid = r_aw_owner ? m1_w_valid : m0_w_valid;
  assign w_own_last  = r_aw_owner ? m1_w_last : m0_w_last;
  assign w_fwd_ok    = w_fwd && !r_w_done;

  assign s_w_valid = w_fwd_ok && w_own_valid;
  assign s_w_data  = r_aw_owner ? m1_w_data : m0_w_data;
  assign s_w_strb  = r_aw_owner ? m1_w_strb : m0_w_strb;
  assign s_w_last  = w_own_last;

  assign m0_w_ready = w_fwd_ok && !r_aw_owner && s_w_ready;
  assign m1_w_ready = w_fwd_ok && r_aw_owner && s_w_ready;

  assign w_wlast_hs = s_w_valid && s_w_ready && w_own_last;

  always_comb begin
    w_aw_next = r_aw_state;
    w_aw_gnt  = 1'b0;
    w_fwd     = 1'b0;
    unique case (r_aw_state)
      AW_IDLE: begin
        if (w_aw_any) begin
          w_aw_gnt  = reset_n;
          w_aw_next = AW_ISSUE;
        end
      end
      AW_ISSUE: begin
        w_fwd = 1'b1;
        // wlast may already be gone before the address is accepted
        if (s_aw_ready)
          w_aw_next = (r_w_done || w_wlast_hs) ? AW_IDLE : W_BURST;
      end
      W_BURST: begin
        w_fwd = 1'b1;
        if (w_wlast_hs)
          w_aw_next = AW_IDLE;
      end
      default: w_aw_next = AW_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_aw_state <= AW_IDLE;
      r_aw_owner <= 1'b0;
      r_aw_last  <= 1'b1;
      r_w_done   <= 1'b0;
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_aw_id    <= '0;
    end else begin
      r_aw_state <= w_aw_next;
      if (w_aw_next == AW_IDLE)
        r_w_done <= 1'b0;
      else if (w_wlast_hs)
        r_w_done <= 1'b1;
      if (w_aw_gnt) begin
        r_aw_owner <= w_aw_sel;
        r_aw_last  <= w_aw_sel;
        r_aw_addr  <= w_aw_sel ? m1_aw_addr : m0_aw_addr;
        r_aw_len   <= w_aw_sel ? m1_aw_len : m0_aw_len;
        r_aw_size  <= w_aw_sel ? m1_aw_size : m0_aw_size;
        r_aw_burst <= w_aw_sel ? m1_aw_burst : m0_aw_burst;
        r_aw_id    <= {w_aw_sel,
                       w_aw_sel ? m1_aw_id : m0_aw_id};
      end
    end
  end

  assign m0_r_valid = s_r_valid && !s_r_id[5];
  assign m1_r_valid = s_r_valid && s_r_id[5];
  assign m0_r_data  = s_r_data;
  assign m1_r_data  = s_r_data;
  assign m0_r_resp  = s_r_resp;
  assign m1_r_resp  = s_r_resp;
  assign m0_r_last  = s_r_last;
  assign m1_r_last  = s_r_last;
  assign m0_r_id    = s_r_id[4:0];
  assign m1_r_id    = s_r_id[4:0];
  assign s_r_ready  = s_r_id[5] ? m1_r_ready : m0_r_ready;

  assign m0_b_valid = s_b_valid && !s_b_id[5];
  assign m1_b_valid = s_b_valid && s_b_id[5];
  assign m0_b_resp  = s_b_resp;
  assign m1_b_resp  = s_b_resp;
  assign m0_b_id    = s_b_id[4:0];
  assign m1_b_id    = s_b_id[4:0];
  assign s_b_ready  = s_b_id[5] ? m1_b_ready : m0_b_ready;

endmodule

// File: doc/mem_axi_arb2.md
MEM_AXI_ARB2 -- requirements
Module: mem_axi_arb2

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning: 0 = round-robin arbitration, 1 = requester 0 always wins ties.
REQ-002 clock  input  1  sole clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 mN_ar_valid/ready, addr[31:0], len[7:0], size[2:0], burst[1:0], id[4:0]  (N=0,1)  requester read-address slave ports; ready is an output.
REQ-005 mN_aw_valid/ready, addr[31:0], len[7:0], size[2:0], burst[1:0], id[4:0]  (N=0,1)  requester write-address slave ports; ready is an output.
REQ-006 mN_w_valid, data[63:0], strb[7:0], last in; mN_w_ready out  requester write-data ports.
REQ-007 mN_r_valid, data[63:0], resp[1:0], last, id[4:0] out; mN_r_ready in  requester read-response ports.
REQ-008 mN_b_valid, resp[1:0], id[4:0] out; mN_b_ready in  requester write-response ports.
REQ-009 s_ar_*, s_aw_*  output bundles (addr 32, len 8, size 3, burst 2, id 6, lock 1, cache 4, prot 3, qos 4, valid) with ready input  toward the shared 64-bit memory AXI slave.
REQ-010 s_w_valid/data[63:0]/strb[7:0]/last out, s_w_ready in; s_r_* and s_b_* in (id 6), s_r_ready/s_b_ready out.

Function
REQ-011 Shared-port ID SHALL be {requester index, requester id[4:0]}; s_*_id[5] identifies the requester.
REQ-012 s_ar_lock/s_aw_lock SHALL be 0, cache 4'b0011, prot 3'b000, qos 4'b0000, constant.
REQ-013 AR path: one output register; when empty, or emptying this cycle (s_ar_valid & s_ar_ready), the block SHALL select a winner among asserted mN_ar_valid, assert mN_ar_ready for that requester only in that cycle, and load the register.
REQ-014 s_ar_valid SHALL rise the cycle after the requester handshake and hold with stable payload until s_ar_ready; back-to-back requests SHALL issue with no bubble.
REQ-015 Round-robin: when both requesters are valid, the requester not granted last SHALL win; a lone valid requester always wins; the pointer updates only on grant; separate pointers for AR and AW.
REQ-016 AW FSM states: AW_IDLE, AW_ISSUE, W_BURST.
REQ-017 AW_IDLE: on any mN_aw_valid, select winner (REQ-015), pulse mN_aw_ready 1 cycle, latch payload and owner, go AW_ISSUE.
REQ-018 AW_ISSUE: s_aw_valid=1 with stable payload; W of owner forwarded; on s_aw_ready go W_BURST, or go AW_IDLE if owner wlast beat already handshaken (w_done flag).
REQ-019 W_BURST: W of owner forwarded; on handshake of beat with last=1 go AW_IDLE; w_done cleared on entry to AW_IDLE.
REQ-020 W forwarding is combinational: s_w_valid = owner w_valid & !w_done, s_w_data/strb/last from owner, owner w_ready = s_w_ready & !w_done; non-owner w_ready SHALL be 0; in AW_IDLE s_w_valid=0 and both w_ready=0.
REQ-021 No new AW grant SHALL occur until the previous burst's wlast has been transferred (W order equals AW order).
REQ-022 R routing combinational: mK_r_valid = s_r_valid & (s_r_id[5]==K), mK_r_id = s_r_id[4:0], data/resp/last broadcast; s_r_ready = selected requester's r_ready.
REQ-023 B routing identical to REQ-022 using s_b_*.
REQ-024 AR and AW arbitration SHALL be independent and may grant in the same cycle.
REQ-025 With FIXED_PRIO=1, requester 0 SHALL win whenever both are valid.

Reset
REQ-026 While reset_n=0: s_ar_valid=0, s_aw_valid=0, all mN_ar_ready/mN_aw_ready/mN_w_ready=0, s_w_valid=0, FSM=AW_IDLE, w_done=0, both RR pointers = requester 1 (so requester 0 wins first tie).
REQ-027 Reset assertion mid-transaction SHALL abort immediately; in-flight bursts are discarded, no recovery required; first grant allowed the cycle after reset_n rises synchronously.

Verification
REQ-028 Both m0/m1 ar_valid continuously, s_ar_ready=1 -> grants alternate 0,1,0,1; s_ar_id[5] sequence 0,1,0,1; one grant per cycle after first.
REQ-029 m1 aw (len=3, id=5'h0A) plus 4 W beats, s_aw_ready delayed 5 cycles, m0 aw_valid meanwhile -> s_aw_id=6'h2A; m0 granted only after m1's 4th (last) beat; m0 w_ready=0 throughout.
REQ-030 W beats with last complete before s_aw_ready -> w_done set, s_w_valid drops, FSM returns AW_IDLE on s_aw_ready.
REQ-031 s_r_valid with s_r_id=6'h23, m1_r_ready=0 -> m1_r_valid=1, m1_r_id=5'h03, m0_r_valid=0, s_r_ready=0 until m1_r_ready=1.
REQ-032 s_ar_ready held 0 for 10 cycles with pending request -> s_ar_valid and payload stable, no further mN_ar_ready pulses.
REQ-033 reset_n pulsed low during W_BURST -> all valids/readies 0 asynchronously; after release, simultaneous requests grant requester 0 first.
